rec_play_seq: RTL and testbench

Record/playback sequencer that drives the SRAM bridge's request side (`addr`, `read`, `write`, write data) and consumes its read data. It sits between the audio codec sample interface and the SRAM bridge. In record mode it writes codec samples to consecutive SRAM words. In play mode it reads those words back, one per DAC request. It also tracks the recorded length so that playback stops at the end of the recording.

---
 rtl/rec_play_pkg.sv | 32 +++
 rtl/rec_play_seq_if.sv | 14 +
 rtl/rec_play_seq_acc_timer.sv | 24 ++
 rtl/rec_play_seq.sv | 194 +++++++++++++++++++
 tb/tb_rec_play_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rec_play_pkg.sv
// Shared types and constants for the record/playback sequencer and the SRAM bridge.
package rec_play_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC_WAIT,
        S_REC_WR,
        S_PLAY_WAIT,
        S_PLAY_RD,
        S_PAUSE
    } seq_state_t;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_REC    = 2'b01,
        MODE_PLAY   = 2'b10,
        MODE_PAUSED = 2'b11
    } seq_mode_t;

    function automatic seq_mode_t state_mode(input seq_state_t s);
        case (s)
            S_REC_WAIT, S_REC_WR:   return MODE_REC;
            S_PLAY_WAIT, S_PLAY_RD: return MODE_PLAY;
            S_PAUSE:                return MODE_PAUSED;
            default:                return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rec_play_seq_if.sv
// Request/response bus between the sequencer (master) and the SRAM bridge (slave).
interface rec_play_seq_if #(
    parameter int ADDR_W = rec_play_pkg::DEF_ADDR_W,
    parameter int DATA_W = rec_play_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_read, mem_write, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_read, mem_write, mem_wdata, output mem_rdata);
endinterface

// File: rtl/rec_play_seq_acc_timer.sv
// Loadable down-counter timing one memory access; last marks the final strobe cycle.
module acc_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/rec_play_seq.sv
// Record/playback sequencer: codec samples to consecutive SRAM words and back.
//   state       | meaning
//   S_IDLE      | no activity, waiting for start_rec / start_play
//   S_REC_WAIT  | recording, waiting for a codec sample
//   S_REC_WR    | write strobe active for ACC_CYC cycles
//   S_PLAY_WAIT | playing, waiting for a DAC request
//   S_PLAY_RD   | read strobe active for ACC_CYC cycles
//   S_PAUSE     | paused; from_play selects the wait state to resume
module rec_play_seq import rec_play_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_CYC = 2,
    parameter int LOOP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    input  logic              pause,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_in,
    input  logic              smp_req,
    output logic [DATA_W-1:0] smp_out,
    output logic              smp_out_valid,
    rec_play_seq_if.master    mem,
    output logic [ADDR_W:0]   rec_len,
    output logic [1:0]        mode,
    output logic              overrun
);
    localparam int CNT_W = $clog2(ACC_CYC + 1);

    seq_state_t state, state_nxt;
    logic from_play, from_play_nxt;
    logic pend_stop, pend_stop_nxt, pend_pause, pend_pause_nxt;
    logic acc_start, acc_last;
    logic rec_clr, play_clr, wr_start, rd_start, wr_done, rd_done, drop, wrap;
    logic is_rd, full, at_end;
    logic [ADDR_W:0] addr_ext;

    assign addr_ext = {1'b0, mem.mem_addr} + 1'b1;
    assign full     = &mem.mem_addr;
    assign at_end   = (addr_ext == rec_len);
    assign is_rd    = (state == S_PLAY_RD);

    acc_timer #(.CNT_W(CNT_W)) u_acc_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (acc_start),
        .load_val (CNT_W'(ACC_CYC)),
        .last     (acc_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            from_play  <= 1'b0;
            pend_stop  <= 1'b0;
            pend_pause <= 1'b0;
        end else begin
            state      <= state_nxt;
            from_play  <= from_play_nxt;
            pend_stop  <= pend_stop_nxt;
            pend_pause <= pend_pause_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        from_play_nxt  = from_play;
        pend_stop_nxt  = pend_stop;
        pend_pause_nxt = pend_pause;
        acc_start      = 1'b0;
        rec_clr        = 1'b0;
        play_clr       = 1'b0;
        wr_start       = 1'b0;
        rd_start       = 1'b0;
        wr_done        = 1'b0;
        rd_done        = 1'b0;
        drop           = 1'b0;
        wrap           = 1'b0;
        case (state)
            S_IDLE: begin
                // stop and pause outrank the start commands even though they do nothing here
                if (!stop && !pause) begin
                    if (start_rec) begin
                        rec_clr   = 1'b1;
                        state_nxt = S_REC_WAIT;
                    end else if (start_play && rec_len != '0) begin
                        play_clr  = 1'b1;
                        state_nxt = S_PLAY_WAIT;
                    end
                end
            end
            S_REC_WAIT: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (pause) begin
                    from_play_nxt = 1'b0;
                    state_nxt     = S_PAUSE;
                end else if (smp_valid) begin
                    wr_start  = 1'b1;
                    acc_start = 1'b1;
                    state_nxt = S_REC_WR;
                end
            end
            S_PLAY_WAIT: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (pause) begin
                    from_play_nxt = 1'b1;
                    state_nxt     = S_PAUSE;
                end else if (smp_req) begin
                    rd_start  = 1'b1;
                    acc_start = 1'b1;
                    state_nxt = S_PLAY_RD;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (pause) begin
                    state_nxt = from_play ? S_PLAY_WAIT : S_REC_WAIT;
                end
            end
            S_REC_WR, S_PLAY_RD: begin
                drop = is_rd ? smp_req : smp_valid;
                if (stop)  pend_stop_nxt  = 1'b1;
                if (pause) pend_pause_nxt = 1'b1;
                if (acc_last) begin
                    pend_stop_nxt  = 1'b0;
                    pend_pause_nxt = 1'b0;
                    from_play_nxt  = is_rd;
                    wr_done        = !is_rd;
                    rd_done        = is_rd;
                    wrap           = is_rd && at_end && (LOOP != 0);
                    if (pend_stop || stop) begin
                        state_nxt = S_IDLE;
                    end else if ((!is_rd && full) || (is_rd && at_end && LOOP == 0)) begin
                        state_nxt = S_IDLE;
                    end else if (pend_pause || pause) begin
                        state_nxt = S_PAUSE;
                    end else begin
                        state_nxt = is_rd ? S_PLAY_WAIT : S_REC_WAIT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_addr  <= '0;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            mem.mem_wdata <= '0;
            smp_out       <= '0;
            smp_out_valid <= 1'b0;
            rec_len       <= '0;
            mode          <= MODE_IDLE;
            overrun       <= 1'b0;
        end else begin
            mode          <= state_mode(state_nxt);
            smp_out_valid <= rd_done;
            if (rec_clr) begin
                mem.mem_addr <= '0;
                rec_len      <= '0;
                overrun      <= 1'b0;
            end
            if (play_clr) begin
                mem.mem_addr <= '0;
                overrun      <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            if (wr_start) begin
                mem.mem_wdata <= smp_in;
                mem.mem_write <= 1'b1;
            end
            if (rd_start) mem.mem_read <= 1'b1;
            // rec_len only moves once the full write strobe has completed
            if (wr_done) begin
                mem.mem_write <= 1'b0;
                rec_len       <= addr_ext;
                mem.mem_addr  <= addr_ext[ADDR_W-1:0];
            end
            if (rd_done) begin
                mem.mem_read <= 1'b0;
                smp_out      <= mem.mem_rdata;
                mem.mem_addr <= wrap ? '0 : addr_ext[ADDR_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_rec_play_seq.sv
// Directed bench: two sequencers (LOOP=0 and LOOP=1, ADDR_W=4) share stimulus, each with its own SRAM model.
module tb_rec_play_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_rec, start_play, stop, pause, smp_valid, smp_req;
    logic [15:0] smp_in;
    logic [15:0] smp_out0, smp_out1;
    logic        vld0, vld1, ovr0, ovr1;
    logic [4:0]  rec_len0, rec_len1;
    logic [1:0]  mode0, mode1;
    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    int          n_vec = 0;
    int          n_err = 0;

    rec_play_seq_if #(.ADDR_W(4), .DATA_W(16)) bus0 ();
    rec_play_seq_if #(.ADDR_W(4), .DATA_W(16)) bus1 ();

    rec_play_seq #(.ADDR_W(4), .DATA_W(16), .ACC_CYC(2), .LOOP(0)) dut0 (
        .clk(clk), .reset(reset), .start_rec(start_rec), .start_play(start_play),
        .stop(stop), .pause(pause), .smp_valid(smp_valid), .smp_in(smp_in),
        .smp_req(smp_req), .smp_out(smp_out0), .smp_out_valid(vld0), .mem(bus0),
        .rec_len(rec_len0), .mode(mode0), .overrun(ovr0)
    );

    rec_play_seq #(.ADDR_W(4), .DATA_W(16), .ACC_CYC(2), .LOOP(1)) dut1 (
        .clk(clk), .reset(reset), .start_rec(start_rec), .start_play(start_play),
        .stop(stop), .pause(pause), .smp_valid(smp_valid), .smp_in(smp_in),
        .smp_req(smp_req), .smp_out(smp_out1), .smp_out_valid(vld1), .mem(bus1),
        .rec_len(rec_len1), .mode(mode1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus0.mem_write) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus1.mem_write) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end
    assign bus0.mem_rdata = mem0[bus0.mem_addr];
    assign bus1.mem_rdata = mem1[bus1.mem_addr];

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rec_sample(input logic [15:0] d, input logic [3:0] a, input string tag);
        smp_valid = 1'b1;
        smp_in    = d;
        cyc();
        smp_valid = 1'b0;
        chk({tag, " wr c1"}, 32'(bus0.mem_write), 1);
        chk({tag, " addr"}, 32'(bus0.mem_addr), 32'(a));
        chk({tag, " wdata"}, 32'(bus0.mem_wdata), 32'(d));
        cyc();
        chk({tag, " wr c2"}, 32'(bus0.mem_write), 1);
        cyc();
        chk({tag, " wr c3"}, 32'(bus0.mem_write), 0);
        chk({tag, " rec_len"}, 32'(rec_len0), 32'(int'(a) + 1));
        chk({tag, " addr inc"}, 32'(bus0.mem_addr), 32'((int'(a) + 1) % 16));
    endtask

    task automatic play_sample(input bit sel, input logic [15:0] d, input string tag);
        smp_req = 1'b1;
        cyc();
        smp_req = 1'b0;
        chk({tag, " rd c1"}, 32'(sel ? bus1.mem_read : bus0.mem_read), 1);
        cyc();
        chk({tag, " rd c2"}, 32'(sel ? bus1.mem_read : bus0.mem_read), 1);
        chk({tag, " early vld"}, 32'(sel ? vld1 : vld0), 0);
        cyc();
        chk({tag, " vld"}, 32'(sel ? vld1 : vld0), 1);
        chk({tag, " data"}, 32'(sel ? smp_out1 : smp_out0), 32'(d));
        chk({tag, " rd c3"}, 32'(sel ? bus1.mem_read : bus0.mem_read), 0);
    endtask

    initial begin
        reset = 1'b1;
        {start_rec, start_play, stop, pause, smp_valid, smp_req} = '0;
        smp_in = '0;
        repeat (3) cyc();
        chk("rst mem_write", 32'(bus0.mem_write), 0);
        reset = 1'b0;
        cyc();
        chk("rst mode", 32'(mode0), 0);
        chk("rst rec_len", 32'(rec_len0), 0);
        chk("rst addr", 32'(bus0.mem_addr), 0);
        chk("rst read", 32'(bus0.mem_read), 0);
        chk("rst wdata", 32'(bus0.mem_wdata), 0);
        chk("rst smp_out", 32'(smp_out0), 0);
        chk("rst vld", 32'(vld0), 0);
        chk("rst overrun", 32'(ovr0), 0);

        // start_play with nothing recorded is ignored
        start_play = 1'b1; cyc(); start_play = 1'b0;
        chk("empty play mode", 32'(mode0), 0);
        cyc();
        chk("empty play read", 32'(bus0.mem_read), 0);

        // record three samples, then stop
        start_rec = 1'b1; cyc(); start_rec = 1'b0;
        chk("rec mode", 32'(mode0), 1);
        rec_sample(16'h1111, 4'd0, "rec0");
        rec_sample(16'h2222, 4'd1, "rec1");
        rec_sample(16'h3333, 4'd2, "rec2");
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("rec stop mode", 32'(mode0), 0);
        chk("rec stop len", 32'(rec_len0), 3);

        // playback without loop
        start_play = 1'b1; cyc(); start_play = 1'b0;
        chk("play mode", 32'(mode0), 2);
        chk("play addr", 32'(bus0.mem_addr), 0);
        play_sample(1'b0, 16'h1111, "play0");
        play_sample(1'b0, 16'h2222, "play1");
        play_sample(1'b0, 16'h3333, "play2");
        chk("play end mode", 32'(mode0), 0);
        chk("play end len", 32'(rec_len0), 3);
        smp_req = 1'b1; cyc(); smp_req = 1'b0;
        chk("play4 no read", 32'(bus0.mem_read), 0);
        cyc(); cyc();
        chk("play4 no vld", 32'(vld0), 0);
        stop = 1'b1; cyc(); stop = 1'b0;

        // looping playback of a two-word recording
        start_rec = 1'b1; cyc(); start_rec = 1'b0;
        rec_sample(16'hAAAA, 4'd0, "lrec0");
        rec_sample(16'h5555, 4'd1, "lrec1");
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("loop len", 32'(rec_len1), 2);
        start_play = 1'b1; cyc(); start_play = 1'b0;
        play_sample(1'b1, 16'hAAAA, "loop0");
        play_sample(1'b1, 16'h5555, "loop1");
        chk("loop wrap addr", 32'(bus1.mem_addr), 0);
        chk("loop still play", 32'(mode1), 2);
        chk("noloop idle", 32'(mode0), 0);
        play_sample(1'b1, 16'hAAAA, "loop2");
        chk("loop addr after", 32'(bus1.mem_addr), 1);
        stop = 1'b1; cyc(); stop = 1'b0;

        // overrun: second sample while the write strobe is active
        start_rec = 1'b1; cyc(); start_rec = 1'b0;
        smp_valid = 1'b1; smp_in = 16'h1234;
        cyc();
        smp_in = 16'h9999;
        chk("ovr wr c1", 32'(bus0.mem_write), 1);
        cyc();
        smp_valid = 1'b0;
        chk("ovr flag", 32'(ovr0), 1);
        chk("ovr wdata kept", 32'(bus0.mem_wdata), 32'h1234);
        cyc();
        chk("ovr rec_len", 32'(rec_len0), 1);
        chk("ovr wr low", 32'(bus0.mem_write), 0);

        // stop during the first strobe cycle lets the write finish
        smp_valid = 1'b1; smp_in = 16'h7777;
        cyc();
        smp_valid = 1'b0; stop = 1'b1;
        chk("stopwr c1", 32'(bus0.mem_write), 1);
        cyc();
        stop = 1'b0;
        chk("stopwr c2", 32'(bus0.mem_write), 1);
        chk("stopwr c2 mode", 32'(mode0), 1);
        cyc();
        chk("stopwr c3", 32'(bus0.mem_write), 0);
        chk("stopwr len", 32'(rec_len0), 2);
        chk("stopwr mode", 32'(mode0), 0);
        chk("stopwr addr", 32'(bus0.mem_addr), 2);
        chk("ovr sticky", 32'(ovr0), 1);

        // stop outranks start_rec
        stop = 1'b1; start_rec = 1'b1; cyc(); stop = 1'b0; start_rec = 1'b0;
        chk("stop+rec mode", 32'(mode0), 0);
        chk("stop+rec len", 32'(rec_len0), 2);

        // fill all 16 words; the 17th sample is ignored
        start_rec = 1'b1; cyc(); start_rec = 1'b0;
        chk("full ovr clr", 32'(ovr0), 0);
        chk("full len clr", 32'(rec_len0), 0);
        for (int k = 0; k < 16; k++) begin
            rec_sample(16'(16'h0100 + k), 4'(k), "full");
        end
        chk("full mode", 32'(mode0), 0);
        chk("full len", 32'(rec_len0), 16);
        smp_valid = 1'b1; smp_in = 16'hDEAD; cyc(); smp_valid = 1'b0;
        chk("full 17 no wr", 32'(bus0.mem_write), 0);
        cyc();
        chk("full 17 mode", 32'(mode0), 0);
        chk("full 17 len", 32'(rec_len0), 16);

        // pause during playback ignores requests without overrun
        start_play = 1'b1; cyc(); start_play = 1'b0;
        chk("pp mode play", 32'(mode0), 2);
        pause = 1'b1; cyc(); pause = 1'b0;
        chk("pp mode paused", 32'(mode0), 3);
        smp_req = 1'b1; cyc(); smp_req = 1'b0;
        chk("pp no read", 32'(bus0.mem_read), 0);
        chk("pp no ovr", 32'(ovr0), 0);
        pause = 1'b1; cyc(); pause = 1'b0;
        chk("pp resume", 32'(mode0), 2);
        play_sample(1'b0, 16'h0100, "pp play");
        chk("pp addr", 32'(bus0.mem_addr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
